// File: rtl/audio_capture.sv
// Records one buffer of mono-mixed codec input samples into on-chip RAM, starting on a
// level trigger. A registered read port lets a playback block stream the buffer back out.
module audio_capture #(
  parameter int              DEPTH  = 24000,
  parameter int              AW     = 15,
  parameter int              DW     = 24,
  parameter logic [DW-1:0]   THRESH = 24'd4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          read_ready,
  input  logic [DW-1:0] readdata_left,
  input  logic [DW-1:0] readdata_right,
  output logic          read,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          armed,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] sample_count
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] wr_addr, wr_addr_nx, count_nx;
  logic          done_nx;
  logic          mem_we;

  logic [DW:0]   sum;
  logic [DW-1:0] mono;
  logic [DW:0]   mono_ext;
  logic [DW:0]   mag;
  logic          loud;
  logic          last;

  logic [DW-1:0] mem [DEPTH];

  // Magnitude is taken one bit wider so the most negative mono value cannot overflow.
  assign sum      = {readdata_left[DW-1], readdata_left} + {readdata_right[DW-1], readdata_right};
  assign mono     = sum[DW:1];
  assign mono_ext = {mono[DW-1], mono};
  assign mag      = mono_ext[DW] ? (~mono_ext + 1'b1) : mono_ext;
  assign loud     = (mag >= {1'b0, THRESH});
  assign last     = (wr_addr == AW'(DEPTH - 1));

  assign armed = (state == ARMED);
  assign busy  = (state == ARMED) || (state == CAPTURE);
  assign read  = read_ready & busy & ~abort;

  always_comb begin
    state_nx   = state;
    wr_addr_nx = wr_addr;
    count_nx   = sample_count;
    done_nx    = done;
    mem_we     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx   = ARMED;
          done_nx    = 1'b0;
          count_nx   = '0;
          wr_addr_nx = '0;
        end
      end
      ARMED, CAPTURE: begin
        if (abort) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end else if (read && (state == CAPTURE || loud)) begin
          mem_we     = 1'b1;
          wr_addr_nx = wr_addr + 1'b1;
          count_nx   = wr_addr + 1'b1;
          if (last) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end else begin
            state_nx = CAPTURE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wr_addr      <= '0;
      sample_count <= '0;
      done         <= 1'b0;
    end else begin
      state        <= state_nx;
      wr_addr      <= wr_addr_nx;
      sample_count <= count_nx;
      done         <= done_nx;
    end
  end

  // RAM contents deliberately survive reset; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= mono;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_audio_capture.sv
// Scoreboard bench for audio_capture: a behavioural capture model predicts per-cycle
// status and buffer contents; a negedge monitor pops and compares against the DUT.
`timescale 1ns/1ps
module tb_audio_capture;

  localparam int DEPTH  = 24000;
  localparam int AW     = 15;
  localparam int DW     = 24;
  localparam int THRESH = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          read_ready = 1'b0;
  logic [DW-1:0] readdata_left = '0;
  logic [DW-1:0] readdata_right = '0;
  logic          read;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          armed;
  logic          busy;
  logic          done;
  logic [AW-1:0] sample_count;

  always #5 clk = ~clk;

  audio_capture #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .THRESH(24'd4096)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .read_ready(read_ready),
    .readdata_left(readdata_left),
    .readdata_right(readdata_right),
    .read(read),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .armed(armed),
    .busy(busy),
    .done(done),
    .sample_count(sample_count)
  );

  typedef struct {
    bit rd;
    bit armed;
    bit busy;
    bit done;
    int count;
  } status_t;

  typedef struct {
    int due;
    int value;
    int addr;
  } rdexp_t;

  status_t exp_q[$];
  rdexp_t  rd_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: mode 0 idle, 1 waiting for trigger, 2 recording, 3 finished
  int mode   = 0;
  int m_cnt  = 0;
  bit m_done = 0;
  int m_mem   [DEPTH];
  bit m_known [DEPTH];

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rand_sample();
    logic [DW-1:0] v;
    v = DW'($urandom);
    return int'($signed(v));
  endfunction

  // One clock of stimulus: predict the outputs visible this cycle, then advance the model.
  task automatic applyStimulus(bit st, bit ab, bit rr, int l, int r, int addr);
    status_t e;
    rdexp_t  x;
    int m, mag;
    @(posedge clk); #1;
    start          = st;
    abort          = ab;
    read_ready     = rr;
    readdata_left  = DW'(l);
    readdata_right = DW'(r);
    rd_addr        = AW'(addr);

    e.armed = (mode == 1);
    e.busy  = (mode == 1) || (mode == 2);
    e.done  = m_done;
    e.count = m_cnt;
    e.rd    = rr && e.busy && !ab;
    exp_q.push_back(e);

    if (m_known[addr]) begin
      x.due   = cyc + 1;
      x.value = m_mem[addr];
      x.addr  = addr;
      rd_q.push_back(x);
    end

    if (mode == 0 || mode == 3) begin
      if (st) begin
        mode   = 1;
        m_done = 0;
        m_cnt  = 0;
      end
    end else if (ab) begin
      mode   = 3;
      m_done = 1;
    end else if (rr) begin
      m   = (l + r) >>> 1;
      mag = (m < 0) ? -m : m;
      if (mode == 2 || mag >= THRESH) begin
        m_mem[m_cnt]   = m;
        m_known[m_cnt] = 1;
        m_cnt++;
        if (m_cnt == DEPTH) begin
          mode   = 3;
          m_done = 1;
        end else begin
          mode = 2;
        end
      end
    end
  endtask

  task automatic idle_cycles(int n, bit rr);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, rr, rand_sample(), rand_sample(), 0);
  endtask

  task automatic readback(int lo, int hi);
    for (int a = lo; a <= hi; a++) applyStimulus(0, 0, 0, 0, 0, a);
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_values(string tag);
    checkOutput({tag, " read"}, int'(read), 0);
    checkOutput({tag, " armed"}, int'(armed), 0);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " done"}, int'(done), 0);
    checkOutput({tag, " sample_count"}, int'(sample_count), 0);
    checkOutput({tag, " rd_data"}, int'(rd_data), 0);
  endtask

  // Asynchronous reset in the middle of a clock period, with read_ready still asserted.
  task automatic do_reset();
    @(posedge clk); #1;
    read_ready = 1'b1;
    reset      = 1'b0;
    #1;
    rd_q.delete();
    check_reset_values("midrun_reset");
    mode   = 0;
    m_cnt  = 0;
    m_done = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin : monitor
    status_t e;
    rdexp_t  x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("read", int'(read), int'(e.rd));
        checkOutput("armed", int'(armed), int'(e.armed));
        checkOutput("busy", int'(busy), int'(e.busy));
        checkOutput("done", int'(done), int'(e.done));
        checkOutput("sample_count", int'(sample_count), e.count);
      end
      while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        x = rd_q.pop_front();
        checkOutput($sformatf("rd_data[%0d]", x.addr), int'($signed(rd_data)), x.value);
      end
    end
  end

  initial begin : stimulus
    int guard;
    #1 reset = 1'b0;
    #2;
    check_reset_values("initial_reset");
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] idle with read_ready high");
    idle_cycles(6, 1);

    $display("[TB] full buffer capture");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 100, 100, 0);
    applyStimulus(0, 0, 1, 5000, 5000, 0);
    guard = 0;
    while (mode != 3 && guard < DEPTH + 10) begin
      applyStimulus(0, 0, 1, rand_sample(), rand_sample(), 0);
      guard++;
    end
    idle_cycles(3, 1);
    readback(0, DEPTH - 1);

    $display("[TB] trigger threshold then abort after 10 samples");
    applyStimulus(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 100, 100, 0);
    applyStimulus(0, 0, 1, 4096, 4096, 0);
    applyStimulus(0, 0, 1, -8192, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, rand_sample(), rand_sample(), 0);
    applyStimulus(0, 1, 1, rand_sample(), rand_sample(), 0);
    idle_cycles(2, 1);
    readback(0, 11);

    $display("[TB] abort before trigger");
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, int'($urandom_range(0, 4000)), -int'($urandom_range(0, 4000)), 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    idle_cycles(2, 0);

    $display("[TB] gapped handshake");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 4096, 4096, 0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(i == 5, 0, (i % 4 == 0) || (i % 4 == 3), rand_sample(), rand_sample(), 0);
    end
    applyStimulus(0, 1, 0, 0, 0, 0);
    readback(0, 22);

    $display("[TB] extremes");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, -8388608, -8388608, 0);
    applyStimulus(0, 0, 1, 8388607, 8388607, 0);
    applyStimulus(0, 0, 1, 8388607, -8388608, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    readback(0, 3);

    $display("[TB] reset during capture");
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, -6000, -6000, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, rand_sample(), rand_sample(), 0);
    do_reset();
    idle_cycles(5, 1);

    for (int i = 0; i < 5 && (exp_q.size() > 0 || rd_q.size() > 0); i++) @(negedge clk);
    checkOutput("scoreboard_drain", exp_q.size() + rd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
